counter_timer_high_wb: RTL

COUNTER_TIMER_HIGH_WB -- requirements
Module: counter_timer_high_wb

---
 rtl/counter_timer_high_wb.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/counter_timer_high_wb.sv
// High word of a chained 64-bit counter/timer with a Wishbone register port.
// Holds CONFIG, VALUE (stop/reload value) and DATA (current value); pairs with a low-word timer.
module counter_timer_high_wb #(
  parameter logic [31:0] BASE_ADR = 32'h2400_0000,
  parameter logic [7:0]  CONFIG   = 8'h00,
  parameter logic [7:0]  VALUE    = 8'h04,
  parameter logic [7:0]  DATA     = 8'h08
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic        wb_ack_o,
  output logic [31:0] wb_dat_o,
  input  logic        enable_in,
  input  logic        stop_in,
  input  logic        strobe,
  input  logic        is_offset,
  output logic        stop_out,
  output logic        enable_out,
  output logic        irq
);

  localparam logic [31:0] ADR_CONFIG = BASE_ADR | {24'd0, CONFIG};
  localparam logic [31:0] ADR_VALUE  = BASE_ADR | {24'd0, VALUE};
  localparam logic [31:0] ADR_DATA   = BASE_ADR | {24'd0, DATA};

  logic [4:0]  r_config;
  logic [31:0] r_value_reset;
  logic [31:0] r_value_cur;
  logic        r_lastenable;
  logic        r_event_d;
  logic        r_irq;

  logic        w_valid;
  logic        w_hit_cfg;
  logic        w_hit_val;
  logic        w_hit_dat;
  logic        w_cfg_wr;
  logic        w_value_wr;
  logic        w_data_wr;
  logic        w_enable;
  logic        w_oneshot;
  logic        w_updown;
  logic        w_chain;
  logic        w_irq_ena;
  logic        w_loc_enable;
  logic [31:0] w_target;
  logic [31:0] w_start;
  logic [31:0] w_step;
  logic        w_stop;
  logic        w_event;
  logic [31:0] w_value_merged;
  logic [31:0] w_data_merged;
  logic [31:0] w_cur_next;

  assign w_valid    = wb_cyc_i & wb_stb_i;
  assign w_hit_cfg  = w_valid & (wb_adr_i == ADR_CONFIG);
  assign w_hit_val  = w_valid & (wb_adr_i == ADR_VALUE);
  assign w_hit_dat  = w_valid & (wb_adr_i == ADR_DATA);
  assign w_cfg_wr   = w_hit_cfg & wb_we_i & wb_sel_i[0];
  assign w_value_wr = w_hit_val & wb_we_i;
  assign w_data_wr  = w_hit_dat & wb_we_i & (|wb_sel_i);

  assign wb_ack_o = w_hit_cfg | w_hit_val | w_hit_dat;

  always_comb begin
    wb_dat_o = '0;
    if (!wb_we_i) begin
      if (w_hit_cfg)
        wb_dat_o = {27'd0, r_config};
      else if (w_hit_val)
        wb_dat_o = r_value_reset;
      else if (w_hit_dat)
        wb_dat_o = r_value_cur;
    end
  end

  // Byte-lane merge so partial writes keep the untouched bytes.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte
      assign w_value_merged[gi*8 +: 8] = wb_sel_i[gi] ? wb_dat_i[gi*8 +: 8] : r_value_reset[gi*8 +: 8];
      assign w_data_merged[gi*8 +: 8]  = wb_sel_i[gi] ? wb_dat_i[gi*8 +: 8] : r_value_cur[gi*8 +: 8];
    end
  endgenerate

  assign w_enable  = r_config[0];
  assign w_oneshot = r_config[1];
  assign w_updown  = r_config[2];
  assign w_chain   = r_config[3];
  assign w_irq_ena = r_config[4];

  assign w_loc_enable = w_chain ? (w_enable & enable_in) : w_enable;

  // With an offset low word the high word must stop one count early.
  assign w_target = w_updown ? (r_value_reset - {31'd0, w_chain & is_offset}) : 32'd0;
  assign w_start  = w_updown ? 32'd0 : r_value_reset;
  assign w_step   = w_updown ? (r_value_cur + 32'd1) : (r_value_cur - 32'd1);
  assign w_stop   = w_loc_enable & (r_value_cur == w_target);
  assign w_event  = w_chain ? (w_stop & stop_in) : w_stop;

  always_comb begin
    w_cur_next = r_value_cur;
    if (w_data_wr) begin
      w_cur_next = w_data_merged;
    end else if (w_loc_enable) begin
      if (!r_lastenable)
        w_cur_next = w_start;
      else if (w_event)
        w_cur_next = w_oneshot ? r_value_cur : w_start;
      else if (!w_chain || strobe)
        w_cur_next = w_step;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_config      <= '0;
      r_value_reset <= '0;
      r_value_cur   <= '0;
      r_lastenable  <= 1'b0;
      r_event_d     <= 1'b0;
      r_irq         <= 1'b0;
    end else begin
      if (w_cfg_wr)
        r_config <= wb_dat_i[4:0];
      if (w_value_wr)
        r_value_reset <= w_value_merged;
      r_value_cur  <= w_cur_next;
      r_lastenable <= w_loc_enable;
      r_event_d    <= w_event & w_loc_enable;
      r_irq        <= w_irq_ena & w_event & w_loc_enable & ~r_event_d;
    end
  end

  assign stop_out   = w_stop;
  assign enable_out = w_enable;
  assign irq        = r_irq;

endmodule
